md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Multiply/divide sequencer for the 5-stage pipelined CPU.
- Sits beside the EX-stage ALU and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo commands from EX and runs each arithmetic op over a fixed multi-cycle latency.
- Raises a stall request so the hazard unit holds later HI/LO-dependent instructions in D.

Parameters:
- MULT_LAT, 5: cycles from accepted mult/multu to HI/LO update (legal range 1..15).
- DIV_LAT, 10: cycles from accepted div/divu to HI/LO update (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  EX-stage command valid.
- op  in  3  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (only with the optional feature).
- a  in  32  operand A: forwarded rs value from EX.
- b  in  32  operand B: forwarded rt value from EX.
- md_in_d  in  1  decode-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo/madd).
- busy  out  1  an arithmetic op is in flight.
- stall_req  out  1  to the hazard unit; ORed into stallF/stallD/flushE.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, state IDLE.
- Reset mid-operation aborts the op; HI/LO are zeroed, not written with partial results.
- States:
  - IDLE to MUL: on start with op 1 or 2 (also 7 when enabled).
  - IDLE to DIV: on start with op 3 or 4.
  - MUL/DIV to IDLE: when the counter reaches its latency.
- Operand capture: a and b are latched on the accept edge N. Later changes on a/b have no effect.
- Arithmetic result is computed combinationally from the latched operands and written at the completion edge.
- Timing for an op accepted at edge N with latency L:
  - busy=1 after edge N.
  - HI/LO are written at edge N+L.
  - busy=0 after edge N+L.
  - busy therefore reads 1 for exactly L cycles.
- mthi/mtlo (op 5/6) with start in IDLE: hi (or lo) takes a at the next edge. Single cycle; busy stays 0.
- start while busy: ignored entirely, any op. The hazard unit guarantees this does not occur; the bench checks that the ignore holds.
- op 0 with start, or op 7 without the optional feature: no effect.
- mult: signed 32x32 to 64; HI = upper 32 bits, LO = lower 32 bits. multu: same, unsigned.
- div: signed, quotient truncated toward zero into LO; remainder takes the sign of the dividend, into HI.
- divu: unsigned.
- Divide by zero:
  - The op still occupies DIV_LAT cycles.
  - HI/LO remain unchanged.
- div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- stall_req = md_in_d & (busy | (start & op in {1,2,3,4,7})). Combinational.
- mfhi/mflo in D therefore waits until busy falls, then reads hi/lo through normal forwarding.
- Counter is 4 bits wide and never wraps. It is reset to 0 on every accept.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined: op 7 (madd) is accepted like mult with MULT_LAT latency. {HI,LO} is updated to {HI,LO} + signed(a)*signed(b), a 64-bit sum that wraps modulo 2^64. The old HI/LO are sampled at the completion edge.
- When undefined: op 7 is a no-op and does not contribute to stall_req.

Test Plan:
- Reset then mult a=0xFFFFFFFF (-1), b=2 accepted at edge 0: busy=1 on cycles 1..5; after edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- multu a=0xFFFFFFFF, b=2: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div a=-7 (0xFFFFFFF9), b=2: after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=7, b=0 with HI/LO preloaded via mthi 0x11/mtlo 0x22: HI=0x11, LO=0x22 after 10 cycles.
- md_in_d=1 held during a div: stall_req=1 on the accept cycle and through all 10 busy cycles, 0 on the cycle after completion. A second start mult during busy leaves the result unchanged.
- rst asserted on cycle 3 of a mult: after that edge busy=0, HI=LO=0. The completion edge never writes.
- With MD_MADD_EN: mtlo 5, mthi 0, then madd a=3, b=4 gives LO=17, HI=0. Without the macro, the same sequence gives LO=5 and busy stays 0.

Source files
------------

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer owning HI/LO: runs mult/div over a fixed latency and requests D-stage stalls.
// Optional madd (op 7, {HI,LO} += a*b signed) is built when MD_MADD_EN is defined.
module md_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [3:0] MULT_LAST = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        arith_op;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;

  always_comb begin
    arith_op = 1'b0;
    case (op)
      3'd1, 3'd2, 3'd3, 3'd4: arith_op = 1'b1;
`ifdef MD_MADD_EN
      3'd7:                   arith_op = 1'b1;
`endif
      default:                arith_op = 1'b0;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = md_in_d & (busy | (start & arith_op));
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign abs_b  = div_b[31] ? (~div_b + 32'd1) : div_b;
  assign mag_q  = abs_a / abs_b;
  assign mag_r  = abs_a % abs_b;
  assign sdiv_q = (a_q[31] ^ div_b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sdiv_r = a_q[31] ? (~mag_r + 32'd1) : mag_r;
  assign udiv_q = a_q / div_b;
  assign udiv_r = a_q % div_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd1, 3'd2: begin
              state_d = MUL;
              cnt_d   = 4'd0;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
`ifdef MD_MADD_EN
            3'd7: begin
              state_d = MUL;
              cnt_d   = 4'd0;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
`endif
            3'd3, 3'd4: begin
              state_d = DIV;
              cnt_d   = 4'd0;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
            3'd5:    hi_d = a;
            3'd6:    lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == MULT_LAST) begin
          state_d = IDLE;
          case (op_q)
            3'd1:    {hi_d, lo_d} = prod_s;
            3'd2:    {hi_d, lo_d} = prod_u;
`ifdef MD_MADD_EN
            3'd7:    {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DIV: begin
        if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          if (b_q != 32'd0) begin
            if (op_q == 3'd3) begin
              hi_d = sdiv_r;
              lo_d = sdiv_q;
            end else begin
              hi_d = udiv_r;
              lo_d = udiv_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
